mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter fronting a synchronous RAM (addr[8:7]=00) and an LED register (01).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise master 0 wins ties.
module mem_arbiter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       m0_req,
    input  logic [8:0] m0_addr,
    input  logic [8:0] m0_wdata,
    input  logic       m0_we,
    output logic       m0_gnt,
    output logic       m0_ack,
    output logic [8:0] m0_rdata,
    input  logic       m1_req,
    input  logic [8:0] m1_addr,
    input  logic [8:0] m1_wdata,
    input  logic       m1_we,
    output logic       m1_gnt,
    output logic       m1_ack,
    output logic [8:0] m1_rdata,
    output logic [6:0] ram_addr,
    output logic [8:0] ram_wdata,
    output logic       ram_wren,
    input  logic [8:0] ram_q,
    output logic       led_we,
    output logic [8:0] led_data,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

    state_e     state_q, state_d;
    logic [8:0] addr_q, wdata_q;
    logic       we_q, id_q;
    logic [8:0] rdata0_q, rdata1_q;
    logic       any_req, win, load;
    logic       in_acc, in_resp, is_ram, is_led;
    logic [8:0] rd_val;

    assign any_req = m0_req | m1_req;
    assign load    = (state_q != StAcc) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    // On a tie the master that did not win last time goes next.
    assign win = (m0_req && m1_req) ? ~last_q : ~m0_req;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else if (load) begin
            last_q <= win;
        end
    end
`else
    assign win = ~m0_req;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StResp: state_d = any_req ? StAcc : StIdle;
            StAcc:          state_d = StResp;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            id_q     <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                addr_q  <= win ? m1_addr  : m0_addr;
                wdata_q <= win ? m1_wdata : m0_wdata;
                we_q    <= win ? m1_we    : m0_we;
                id_q    <= win;
            end
            if (in_resp) begin
                if (id_q) rdata1_q <= rd_val;
                else      rdata0_q <= rd_val;
            end
        end
    end

    assign in_acc  = (state_q == StAcc);
    assign in_resp = (state_q == StResp);
    assign is_ram  = (addr_q[8:7] == 2'b00);
    assign is_led  = (addr_q[8:7] == 2'b01);
    // RAM data arrives during RESP; LED, unmapped and writes read as zero.
    assign rd_val  = (!we_q && is_ram) ? ram_q : 9'd0;

    assign m0_gnt   = in_acc & ~id_q;
    assign m1_gnt   = in_acc & id_q;
    assign m0_ack   = in_resp & ~id_q & resetn;
    assign m1_ack   = in_resp & id_q & resetn;
    assign m0_rdata = (in_resp && !id_q) ? rd_val : rdata0_q;
    assign m1_rdata = (in_resp && id_q)  ? rd_val : rdata1_q;

    assign ram_addr  = addr_q[6:0];
    assign ram_wdata = wdata_q;
    assign ram_wren  = in_acc & we_q & is_ram & resetn;
    assign led_we    = in_acc & we_q & is_led & resetn;
    assign led_data  = in_acc ? wdata_q : 9'd0;
    assign busy      = in_acc | in_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous RAM model and pulse monitors.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [8:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [8:0] m0_rdata, m1_rdata;
    logic [6:0] ram_addr;
    logic [8:0] ram_wdata, ram_q, led_data;
    logic       ram_wren, led_we, busy;

    logic [8:0] mem [128];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_ramw = 0, n_ledw = 0, n_ack1 = 0, n_both = 0;
    logic [6:0] last_ramw_addr;
    logic [8:0] last_led_data;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .resetn   (resetn),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_we    (m0_we),
        .m0_gnt   (m0_gnt),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_we    (m1_we),
        .m1_gnt   (m1_gnt),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wren (ram_wren),
        .ram_q    (ram_q),
        .led_we   (led_we),
        .led_data (led_data),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr]  <= ram_wdata;
            n_ramw         <= n_ramw + 1;
            last_ramw_addr <= ram_addr;
        end
        ram_q <= mem[ram_addr];
        if (led_we) begin
            n_ledw        <= n_ledw + 1;
            last_led_data <= led_data;
        end
        if (m1_ack) n_ack1 <= n_ack1 + 1;
        if ((m0_gnt && m1_gnt) || (m0_ack && m1_ack)) n_both <= n_both + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Called at a negedge; issues one access and returns the read data seen with ack.
    task automatic access(input int m, input logic [8:0] a, input logic [8:0] d, input logic w,
                          output logic [8:0] rd);
        int cyc = 0;
        bit got = 0;
        rd = 'x;
        if (m == 0) begin
            m0_req = 1'b1; m0_addr = a; m0_wdata = d; m0_we = w;
        end else begin
            m1_req = 1'b1; m1_addr = a; m1_wdata = d; m1_we = w;
        end
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            got = (m == 0) ? m0_gnt : m1_gnt;
        end
        check_eq("gnt_latency", cyc, 1);
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
        if (got) begin
            @(negedge clk);
            check_eq("ack", (m == 0) ? m0_ack : m1_ack, 1);
            rd = (m == 0) ? m0_rdata : m1_rdata;
        end
    endtask

    initial begin
        logic [8:0] rd;
        int         ramw0, ledw0, ack0, n;
        int         seq [4];
        int         tg [4];
        logic [8:0] a100;

        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        a100 = 9'h100;
        @(negedge clk);
        do_reset();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_gnt", {m0_gnt, m1_gnt, m0_ack, m1_ack}, 0);
        check_eq("rst_rdata", {m0_rdata, m1_rdata}, 0);
        check_eq("rst_strobes", {ram_wren, led_we}, 0);

        // RAM write then read back through master 0.
        ramw0 = n_ramw;
        access(0, 9'h005, 9'h1A3, 1'b1, rd);
        check_eq("ram_wr_count", n_ramw - ramw0, 1);
        check_eq("ram_wr_addr", last_ramw_addr, 5);
        access(0, 9'h005, 9'h000, 1'b0, rd);
        check_eq("ram_rd_data", rd, 9'h1A3);
        @(negedge clk);
        check_eq("rdata_hold", m0_rdata, 9'h1A3);

        // LED write from master 1.
        ramw0 = n_ramw; ledw0 = n_ledw;
        access(1, 9'h080, 9'h055, 1'b1, rd);
        check_eq("led_we_count", n_ledw - ledw0, 1);
        check_eq("led_data", last_led_data, 9'h055);
        check_eq("led_no_ramw", n_ramw - ramw0, 0);

        // Unmapped write is dropped, unmapped read returns zero.
        ramw0 = n_ramw; ledw0 = n_ledw;
        access(0, a100, 9'h1FF, 1'b1, rd);
        check_eq("unm_no_write", (n_ramw - ramw0) + (n_ledw - ledw0), 0);
        access(0, a100, 9'h000, 1'b0, rd);
        check_eq("unm_rd_zero", rd, 0);

        // Both masters request continuously for four accesses.
        do_reset();
        m0_req = 1; m0_addr = 9'h00A; m0_we = 0;
        m1_req = 1; m1_addr = 9'h00B; m1_we = 0;
        n = 0;
        for (int c = 1; c <= 20 && n < 4; c++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                seq[n] = m1_gnt ? 1 : 0;
                tg[n]  = c;
                n++;
            end
        end
        m0_req = 0; m1_req = 0;
        check_eq("tie_grants", n, 4);
        if (n == 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
                check_eq("tie_winner", seq[i], i % 2);
`else
                check_eq("tie_winner", seq[i], 0);
`endif
            end
            check_eq("tie_throughput", tg[3] - tg[0], 6);
        end
        repeat (2) @(negedge clk);
        check_eq("gnt_exclusive", n_both, 0);

        // Reset during ACC of a master 1 RAM write aborts it.
        ramw0 = n_ramw; ack0 = n_ack1;
        m1_req = 1; m1_addr = 9'h010; m1_wdata = 9'h0AB; m1_we = 1;
        @(negedge clk);
        check_eq("abort_in_acc", m1_gnt, 1);
        resetn = 0;
        #1;
        check_eq("abort_wren_low", ram_wren, 0);
        @(negedge clk);
        m1_req = 0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_no_ack", n_ack1 - ack0, 0);
        check_eq("abort_no_ramw", n_ramw - ramw0, 0);
        resetn = 1;
        repeat (2) @(negedge clk);
        check_eq("abort_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
